// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: pipeline vs long-latency writeback,
// with a busy scoreboard that stalls decode on hazards to pending results.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  input  logic [4:0]  p_waddr,
  input  logic [31:0] p_wdata,
  output logic        p_ready,
  input  logic        l_valid,
  input  logic [4:0]  l_waddr,
  input  logic [31:0] l_wdata,
  output logic        l_ready,
  input  logic        iss_valid,
  input  logic        iss_long,
  input  logic [4:0]  iss_rd,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic        stall,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [5:0]  busy_cnt
);

  typedef enum logic {
    NORMAL,
    FORCE_LONG
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic [31:0]      busy, busy_nxt;
  logic [5:0]       cnt_nxt;
  logic             p_gnt, l_gnt;
  logic             set_en, clr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    p_ready   = 1'b0;
    l_ready   = 1'b0;
    if (rst) begin
      unique case (state)
        NORMAL: begin
          p_ready = p_valid;
          l_ready = l_valid & ~p_valid;
          if (l_valid && !l_ready) begin
            wait_nxt = wait_cnt + 1'b1;
            if (wait_cnt == CNT_W'(MAX_WAIT - 1))
              state_nxt = FORCE_LONG;
          end else begin
            wait_nxt = '0;
          end
        end
        FORCE_LONG: begin
          // A forced slot lasts one cycle, granted or abandoned
          l_ready   = l_valid;
          state_nxt = NORMAL;
          wait_nxt  = '0;
        end
        default: state_nxt = NORMAL;
      endcase
    end
  end

  assign p_gnt = p_valid & p_ready;
  assign l_gnt = l_valid & l_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= 1'b0;
      unique case (1'b1)
        p_gnt: if (p_waddr != 5'd0) begin
          we    <= 1'b1;
          waddr <= p_waddr;
          wdata <= p_wdata;
        end
        l_gnt: if (l_waddr != 5'd0) begin
          we    <= 1'b1;
          waddr <= l_waddr;
          wdata <= l_wdata;
        end
        default: ;
      endcase
    end
  end

  assign stall = rst & ((re1 & busy[raddr1]) |
                        (re2 & busy[raddr2]) |
                        (iss_valid & busy[iss_rd] & (iss_rd != 5'd0)));

  assign set_en = iss_valid & iss_long & (iss_rd != 5'd0) & ~stall;
  assign clr_en = l_gnt;

  always_comb begin
    busy_nxt = busy;
    if (clr_en)
      busy_nxt[l_waddr] = 1'b0;
    // Set applied last so a new issue wins over a same-cycle retire
    if (set_en)
      busy_nxt[iss_rd] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < 32; i++)
      cnt_nxt = cnt_nxt + {5'd0, busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, starvation,
// scoreboard set/clear, x0 handling and mid-operation reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_valid = 1'b0;
  logic [4:0]  p_waddr = '0;
  logic [31:0] p_wdata = '0;
  logic        p_ready;
  logic        l_valid = 1'b0;
  logic [4:0]  l_waddr = '0;
  logic [31:0] l_wdata = '0;
  logic        l_ready;
  logic        iss_valid = 1'b0;
  logic        iss_long = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic        stall;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [5:0]  busy_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .p_ready(p_ready),
    .l_valid(l_valid), .l_waddr(l_waddr), .l_wdata(l_wdata),
    .l_ready(l_ready),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .stall(stall), .we(we), .waddr(waddr), .wdata(wdata),
    .busy_cnt(busy_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shadow of outstanding long destinations; a pipeline write into one
  // of them means decode let a WAW hazard through.
  logic [31:0] sb;
  always @(posedge clk or negedge rst) begin
    if (!rst) sb <= '0;
    else begin
      assert (!(p_valid && p_ready && p_waddr != 5'd0 && sb[p_waddr]))
        else begin
          n_bad++;
          $error("FAIL wb_to_busy: reg %0d written while busy", p_waddr);
        end
      if (l_valid && l_ready) sb[l_waddr] <= 1'b0;
      if (iss_valid && iss_long && iss_rd != 5'd0 && !stall)
        sb[iss_rd] <= 1'b1;
    end
  end

  initial begin
    // reset, with a stray pipeline request that must not be accepted
    #2 rst = 1'b0;
    p_valid = 1'b1;
    #1;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_cnt", busy_cnt, 0);
    chk("rst_pready", p_ready, 0);
    chk("rst_stall", stall, 0);
    p_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("idle_we", we, 0);
    chk("idle_stall", stall, 0);
    chk("idle_cnt", busy_cnt, 0);
    chk("idle_pready", p_ready, 0);
    chk("idle_lready", l_ready, 0);

    // pipeline write
    p_valid = 1'b1; p_waddr = 5'd5; p_wdata = 32'hDEADBEEF;
    #1;
    chk("pw_pready", p_ready, 1);
    chk("pw_lready", l_ready, 0);
    step();
    p_valid = 1'b0;
    chk("pw_we", we, 1);
    chk("pw_waddr", waddr, 5);
    chk("pw_wdata", wdata, 32'hDEADBEEF);
    step();
    chk("pw_we_off", we, 0);
    chk("pw_waddr_hold", waddr, 5);

    // RAW / WAW on a long result for x7
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
    #1;
    chk("raw_iss_stall", stall, 0);
    step();
    iss_valid = 1'b0;
    chk("raw_cnt1", busy_cnt, 1);
    re1 = 1'b1; raddr1 = 5'd7;
    #1;
    chk("raw_stall_r1", stall, 1);
    re1 = 1'b0; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    chk("raw_stall_r2", stall, 1);
    re2 = 1'b0; iss_valid = 1'b1; iss_long = 1'b0;
    #1;
    chk("waw_stall", stall, 1);
    iss_valid = 1'b0; re1 = 1'b1;
    l_valid = 1'b1; l_waddr = 5'd7; l_wdata = 32'h12;
    #1;
    chk("raw_lready", l_ready, 1);
    chk("raw_stall_acc", stall, 1);
    step();
    l_valid = 1'b0;
    #1;
    chk("raw_stall_off", stall, 0);
    chk("raw_we", we, 1);
    chk("raw_waddr", waddr, 7);
    chk("raw_wdata", wdata, 32'h12);
    chk("raw_cnt0", busy_cnt, 0);
    re1 = 1'b0;

    // starvation: four refusals, then a forced long grant
    p_valid = 1'b1; p_waddr = 5'd1; p_wdata = 32'h11;
    l_valid = 1'b1; l_waddr = 5'd3; l_wdata = 32'h33;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("stv_pready%0d", k), p_ready, 1);
      chk($sformatf("stv_lready%0d", k), l_ready, 0);
      step();
    end
    #1;
    chk("stv_force_p", p_ready, 0);
    chk("stv_force_l", l_ready, 1);
    step();
    l_valid = 1'b0;
    #1;
    chk("stv_we", we, 1);
    chk("stv_waddr", waddr, 3);
    chk("stv_wdata", wdata, 32'h33);
    chk("stv_resume", p_ready, 1);
    step();
    p_valid = 1'b0;
    chk("stv_pwaddr", waddr, 1);

    // same-cycle retire and issue of x9: the issue wins
    l_valid = 1'b1; l_waddr = 5'd9; l_wdata = 32'h99;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9;
    #1;
    chk("sc_stall", stall, 0);
    chk("sc_lready", l_ready, 1);
    step();
    l_valid = 1'b0; iss_valid = 1'b0;
    re1 = 1'b1; raddr1 = 5'd9;
    #1;
    chk("sc_cnt", busy_cnt, 1);
    chk("sc_busy9", stall, 1);
    re1 = 1'b0;
    l_valid = 1'b1;
    step();
    l_valid = 1'b0;
    chk("sc_cnt_clr", busy_cnt, 0);
    chk("sc_waddr", waddr, 9);

    // x0 handling
    p_valid = 1'b1; p_waddr = 5'd0; p_wdata = 32'hAAAA;
    #1;
    chk("x0_pready", p_ready, 1);
    step();
    p_valid = 1'b0;
    chk("x0_we", we, 0);
    chk("x0_waddr_hold", waddr, 9);
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd0;
    step();
    iss_valid = 1'b0;
    re1 = 1'b1; raddr1 = 5'd0;
    #1;
    chk("x0_cnt", busy_cnt, 0);
    chk("x0_stall", stall, 0);
    re1 = 1'b0;
    l_valid = 1'b1; l_waddr = 5'd0;
    step();
    l_valid = 1'b0;
    chk("x0_lwe", we, 0);

    // three outstanding results, then reset while in the forced slot
    iss_valid = 1'b1; iss_long = 1'b1;
    for (int r = 10; r < 13; r++) begin
      iss_rd = 5'(r);
      step();
    end
    iss_valid = 1'b0;
    chk("mr_cnt3", busy_cnt, 3);
    p_valid = 1'b1; p_waddr = 5'd2; p_wdata = 32'h22;
    l_valid = 1'b1; l_waddr = 5'd10; l_wdata = 32'hA0;
    repeat (4) step();
    chk("mr_force", l_ready, 1);
    chk("mr_we_pre", we, 1);
    rst = 1'b0;
    #1;
    chk("mr_cnt0", busy_cnt, 0);
    chk("mr_we0", we, 0);
    chk("mr_lready0", l_ready, 0);
    chk("mr_pready0", p_ready, 0);
    step();
    rst = 1'b1;
    #1;
    chk("mr_normal_p", p_ready, 1);
    chk("mr_normal_l", l_ready, 0);
    p_valid = 1'b0; l_valid = 1'b0;
    re1 = 1'b1; raddr1 = 5'd10;
    #1;
    chk("mr_stall", stall, 0);
    re1 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
